// File: rtl/biriscv_commit_buffer.sv
// Commit record FIFO between the writeback stage and an external lockstep checker.
// Every retired or trapping instruction gets a sequence number so dropped records show up as gaps.
`timescale 1ns/1ps
module biriscv_commit_buffer #(
  parameter int DEPTH    = 8,
  parameter int DEPTH_W  = 3,
  parameter int HEADROOM = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_wb_i,
  input  logic [4:0]         rd_wb_i,
  input  logic [31:0]        result_wb_i,
  input  logic [31:0]        pc_wb_i,
  input  logic [31:0]        opcode_wb_i,
  input  logic [5:0]         exception_wb_i,
  input  logic               csr_write_wb_i,
  input  logic [11:0]        csr_waddr_wb_i,
  input  logic [31:0]        csr_wdata_wb_i,
  input  logic               flush_i,
  input  logic               clr_overflow_i,
  output logic               entry_valid_o,
  input  logic               entry_accept_i,
  output logic [15:0]        entry_seq_o,
  output logic [31:0]        entry_pc_o,
  output logic [31:0]        entry_opcode_o,
  output logic [31:0]        entry_result_o,
  output logic [4:0]         entry_rd_o,
  output logic [5:0]         entry_exception_o,
  output logic               entry_csr_write_o,
  output logic [11:0]        entry_csr_waddr_o,
  output logic [31:0]        entry_csr_wdata_o,
  output logic [DEPTH_W:0]   level_o,
  output logic               stall_o,
  output logic               overflow_o
);

  typedef struct packed {
    logic [15:0] seq;
    logic [31:0] pc;
    logic [31:0] opcode;
    logic [31:0] result;
    logic [4:0]  rd;
    logic [5:0]  exception;
    logic        csr_write;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
  } rec_t;

  localparam logic [DEPTH_W:0] FULL_LVL  = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0] STALL_LVL = (DEPTH_W+1)'(DEPTH - HEADROOM);

  rec_t               mem_q [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr_q;
  logic [DEPTH_W-1:0] rd_ptr_q;
  logic [DEPTH_W:0]   count_q;
  logic [15:0]        seq_q;
  logic               overflow_q;

  logic cap;
  logic empty;
  logic full;
  logic push;
  logic pop;
  logic drop;
  rec_t wr_rec;
  rec_t head_rec;

  assign cap   = valid_wb_i | (|exception_wb_i);
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_LVL);
  assign pop   = ~empty & entry_accept_i & ~flush_i;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push  = cap & ~flush_i & (~full | pop);
  assign drop  = cap & ~flush_i & full & ~pop;

  assign wr_rec = '{seq:       seq_q,
                    pc:        pc_wb_i,
                    opcode:    opcode_wb_i,
                    result:    result_wb_i,
                    rd:        rd_wb_i,
                    exception: exception_wb_i,
                    csr_write: csr_write_wb_i,
                    csr_waddr: csr_waddr_wb_i,
                    csr_wdata: csr_wdata_wb_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Sequence advances on every capture, including dropped and flushed ones.
      if (cap)
        seq_q <= seq_q + 16'd1;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push)
          wr_ptr_q <= wr_ptr_q + DEPTH_W'(1);
        if (pop)
          rd_ptr_q <= rd_ptr_q + DEPTH_W'(1);
        if (push && !pop)
          count_q <= count_q + (DEPTH_W+1)'(1);
        else if (pop && !push)
          count_q <= count_q - (DEPTH_W+1)'(1);
      end
      if (drop)
        overflow_q <= 1'b1;
      else if (clr_overflow_i)
        overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_rec;
  end

  assign head_rec = empty ? '0 : mem_q[rd_ptr_q];

  assign entry_valid_o     = ~empty;
  assign entry_seq_o       = head_rec.seq;
  assign entry_pc_o        = head_rec.pc;
  assign entry_opcode_o    = head_rec.opcode;
  assign entry_result_o    = head_rec.result;
  assign entry_rd_o        = head_rec.rd;
  assign entry_exception_o = head_rec.exception;
  assign entry_csr_write_o = head_rec.csr_write;
  assign entry_csr_waddr_o = head_rec.csr_waddr;
  assign entry_csr_wdata_o = head_rec.csr_wdata;
  assign level_o           = count_q;
  // Registered count only, so issue stall never loops back through the capture path.
  assign stall_o           = (count_q >= STALL_LVL);
  assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_biriscv_commit_buffer.sv
// Scoreboard bench for biriscv_commit_buffer: stimulus queues expected records, a monitor checks each pop.
`timescale 1ns/1ps
module tb_biriscv_commit_buffer;

  typedef struct packed {
    logic [15:0] seq;
    logic [31:0] pc;
    logic [31:0] opcode;
    logic [31:0] result;
    logic [4:0]  rd;
    logic [5:0]  exception;
    logic        csr_write;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
  } rec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_wb_i = 1'b0;
  logic [4:0]  rd_wb_i = '0;
  logic [31:0] result_wb_i = '0;
  logic [31:0] pc_wb_i = '0;
  logic [31:0] opcode_wb_i = '0;
  logic [5:0]  exception_wb_i = '0;
  logic        csr_write_wb_i = 1'b0;
  logic [11:0] csr_waddr_wb_i = '0;
  logic [31:0] csr_wdata_wb_i = '0;
  logic        flush_i = 1'b0;
  logic        clr_overflow_i = 1'b0;
  logic        entry_accept_i = 1'b0;
  logic        entry_valid_o;
  logic [15:0] entry_seq_o;
  logic [31:0] entry_pc_o;
  logic [31:0] entry_opcode_o;
  logic [31:0] entry_result_o;
  logic [4:0]  entry_rd_o;
  logic [5:0]  entry_exception_o;
  logic        entry_csr_write_o;
  logic [11:0] entry_csr_waddr_o;
  logic [31:0] entry_csr_wdata_o;
  logic [3:0]  level_o;
  logic        stall_o;
  logic        overflow_o;

  int total = 0;
  int bad   = 0;

  rec_t        expQ[$];
  int          mCount = 0;
  logic [15:0] mSeq = '0;
  logic        mOverflow = 1'b0;

  biriscv_commit_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_wb_i(valid_wb_i), .rd_wb_i(rd_wb_i), .result_wb_i(result_wb_i),
    .pc_wb_i(pc_wb_i), .opcode_wb_i(opcode_wb_i), .exception_wb_i(exception_wb_i),
    .csr_write_wb_i(csr_write_wb_i), .csr_waddr_wb_i(csr_waddr_wb_i),
    .csr_wdata_wb_i(csr_wdata_wb_i), .flush_i(flush_i), .clr_overflow_i(clr_overflow_i),
    .entry_valid_o(entry_valid_o), .entry_accept_i(entry_accept_i),
    .entry_seq_o(entry_seq_o), .entry_pc_o(entry_pc_o), .entry_opcode_o(entry_opcode_o),
    .entry_result_o(entry_result_o), .entry_rd_o(entry_rd_o),
    .entry_exception_o(entry_exception_o), .entry_csr_write_o(entry_csr_write_o),
    .entry_csr_waddr_o(entry_csr_waddr_o), .entry_csr_wdata_o(entry_csr_wdata_o),
    .level_o(level_o), .stall_o(stall_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: mid-cycle, any head that will be consumed at the next edge is checked against the queue.
  always @(negedge clk_i) begin
    rec_t act;
    rec_t exp;
    if (!rst_i && entry_valid_o && entry_accept_i && !flush_i) begin
      act = '{entry_seq_o, entry_pc_o, entry_opcode_o, entry_result_o, entry_rd_o,
              entry_exception_o, entry_csr_write_o, entry_csr_waddr_o, entry_csr_wdata_o};
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL pop_unexpected: got seq=%h pc=%h, required no record", act.seq, act.pc);
      end else begin
        exp = expQ.pop_front();
        if (act !== exp) begin
          bad++;
          $display("[TB] FAIL pop_record: got seq=%h pc=%h op=%h res=%h rd=%h exc=%h csr=%b/%h/%h, required seq=%h pc=%h op=%h res=%h rd=%h exc=%h csr=%b/%h/%h",
                   act.seq, act.pc, act.opcode, act.result, act.rd, act.exception,
                   act.csr_write, act.csr_waddr, act.csr_wdata,
                   exp.seq, exp.pc, exp.opcode, exp.result, exp.rd, exp.exception,
                   exp.csr_write, exp.csr_waddr, exp.csr_wdata);
        end
      end
    end
  end

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic checkOutput();
    check1("entry_valid", 32'(entry_valid_o), 32'(mCount != 0));
    check1("level", 32'(level_o), 32'(mCount));
    check1("stall", 32'(stall_o), 32'(mCount >= 5));
    check1("overflow", 32'(overflow_o), 32'(mOverflow));
    if (mCount == 0) begin
      check1("empty_seq_zero", 32'(entry_seq_o), 32'h0);
      check1("empty_pc_zero", entry_pc_o, 32'h0);
    end
  endtask

  // One cycle: drive inputs, advance the reference model, then compare state after the edge.
  task automatic applyStimulus(input logic vld, input logic [5:0] exc, input logic [31:0] pc,
                               input logic acc, input logic fl, input logic clr);
    logic cap, pop, push, drop;
    rec_t r;
    valid_wb_i     = vld;
    exception_wb_i = exc;
    pc_wb_i        = pc;
    rd_wb_i        = pc[6:2];
    result_wb_i    = pc ^ 32'hA5A5_0F0F;
    opcode_wb_i    = pc + 32'h13;
    csr_write_wb_i = pc[2];
    csr_waddr_wb_i = pc[13:2];
    csr_wdata_wb_i = ~pc;
    entry_accept_i = acc;
    flush_i        = fl;
    clr_overflow_i = clr;
    cap  = vld | (exc != 6'd0);
    pop  = (mCount != 0) & acc & ~fl;
    push = cap & ~fl & ((mCount < 8) | pop);
    drop = cap & ~fl & (mCount == 8) & ~pop;
    r = '{mSeq, pc, pc + 32'h13, pc ^ 32'hA5A5_0F0F, pc[6:2], exc, pc[2], pc[13:2], ~pc};
    if (fl) begin
      expQ.delete();
      mCount = 0;
    end else begin
      if (push) expQ.push_back(r);
      mCount = mCount + int'(push) - int'(pop);
    end
    if (cap) mSeq = mSeq + 16'd1;
    if (drop) mOverflow = 1'b1;
    else if (clr) mOverflow = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    valid_wb_i = 1'b0; exception_wb_i = '0; entry_accept_i = 1'b0;
    flush_i = 1'b0; clr_overflow_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    expQ.delete();
    mCount = 0; mSeq = '0; mOverflow = 1'b0;
    checkOutput();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mCount != 0; i++)
      applyStimulus(1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    doReset();

    // Three captures with the checker always ready.
    applyStimulus(1'b1, 6'd0, 32'h100, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd0, 32'h104, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd0, 32'h108, 1'b1, 1'b0, 1'b0);
    drain();

    // Fill to full, then overflow while clearing in the same cycle (set wins).
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 6'd0, 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd0, 32'h220, 1'b0, 1'b0, 1'b1);
    check1("overflow_set", 32'(overflow_o), 32'h1);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Full with capture and accept together: level holds at 8, nothing lost.
    applyStimulus(1'b1, 6'd0, 32'h300, 1'b1, 1'b0, 1'b0);
    check1("full_push_pop_level", 32'(level_o), 32'd8);
    drain();

    // Trap without a valid writeback still records.
    applyStimulus(1'b0, 6'h10, 32'h400, 1'b0, 1'b0, 1'b0);
    drain();

    // Flush with capture and accept active, then a fresh capture shows the gap.
    applyStimulus(1'b1, 6'd0, 32'h500, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd0, 32'h504, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd0, 32'h508, 1'b1, 1'b1, 1'b0);
    check1("flush_level", 32'(level_o), 32'h0);
    applyStimulus(1'b1, 6'd0, 32'h50C, 1'b0, 1'b0, 1'b0);
    check1("post_flush_seq", 32'(entry_seq_o), 32'(mSeq - 16'd1));
    drain();

    // Reset with records buffered, then walk the sequence up to the wrap point.
    applyStimulus(1'b1, 6'd0, 32'h600, 1'b0, 1'b0, 1'b0);
    doReset();
    for (int i = 0; i < 65534; i++)
      applyStimulus(1'b1, 6'd0, 32'h1000, 1'b1, 1'b0, 1'b0);
    drain();
    applyStimulus(1'b1, 6'd0, 32'h700, 1'b0, 1'b0, 1'b0);
    check1("seq_fffe", 32'(entry_seq_o), 32'hFFFE);
    applyStimulus(1'b1, 6'd0, 32'h704, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd0, 32'h708, 1'b0, 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
